// File: rtl/fetch_stage.sv
//==============================================================================
// Module   : fetch_stage
// Brief    : RISC-V instruction-fetch stage. Owns the PC, addresses the
//            asynchronous instruction ROM and fills the IF/ID register.
//            Supports stall, taken-branch redirect with flush, and halt on
//            EBREAK.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module fetch_stage #(
  parameter int                     TAM_POSICIONES = 1024,
  parameter int                     TAM_PALABRA    = 32,
  parameter logic [31:0]            RESET_PC       = 32'h0000_0000,
  parameter logic [TAM_PALABRA-1:0] NOP_INSTR      = 32'h0000_0013,
  localparam int                    AW             = $clog2(TAM_POSICIONES)
) (
  input  logic                   CLK,
  input  logic                   RESET,
  input  logic                   STALL,
  input  logic                   BRANCH_TAKEN,
  input  logic [31:0]            BRANCH_TARGET,
  output logic                   READ_EN,
  output logic [AW-1:0]          INS_ADDRESS,
  input  logic [TAM_PALABRA-1:0] INSTRUCTION_IN,
  output logic [31:0]            PC_ID,
  output logic [TAM_PALABRA-1:0] INSTRUCTION_ID,
  output logic                   VALID_ID,
  output logic                   HALTED,
  output logic                   MISALIGNED
);

  localparam logic [1:0] S_BOOT = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_HALT = 2'd2;

  localparam logic [TAM_PALABRA-1:0] C_EBREAK = TAM_PALABRA'(32'h0010_0073);

  logic [1:0]             state_q, state_d;
  logic [31:0]            pc_q, pc_d;
  logic [31:0]            pc_id_q, pc_id_d;
  logic [TAM_PALABRA-1:0] instr_id_q, instr_id_d;
  logic                   valid_id_q, valid_id_d;
  logic                   mis_q, mis_d;
  logic                   is_ebreak;

  assign is_ebreak = (INSTRUCTION_IN == C_EBREAK);

  // State register.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) state_q <= S_BOOT;
    else       state_q <= state_d;
  end

  // Next-state: BOOT lasts one cycle; a non-redirected, non-stalled EBREAK halts.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_BOOT: state_d = S_RUN;
      S_RUN:  if (!BRANCH_TAKEN && !STALL && is_ebreak) state_d = S_HALT;
      S_HALT: state_d = S_HALT;
      default: state_d = S_BOOT;
    endcase
  end

  // State-decoded outputs.
  always_comb begin
    READ_EN = (state_q == S_RUN);
    HALTED  = (state_q == S_HALT);
  end

  // Datapath next values: branch beats stall beats normal fetch.
  always_comb begin
    pc_d       = pc_q;
    pc_id_d    = pc_id_q;
    instr_id_d = instr_id_q;
    valid_id_d = valid_id_q;
    mis_d      = 1'b0;
    case (state_q)
      S_RUN: begin
        if (BRANCH_TAKEN) begin
          // Redirect: realign target, flush IF/ID with a bubble.
          pc_d       = {BRANCH_TARGET[31:2], 2'b00};
          instr_id_d = NOP_INSTR;
          valid_id_d = 1'b0;
          mis_d      = |BRANCH_TARGET[1:0];
        end else if (!STALL) begin
          pc_id_d    = pc_q;
          instr_id_d = INSTRUCTION_IN;
          valid_id_d = 1'b1;
          // EBREAK freezes the PC on its own address.
          if (!is_ebreak) pc_d = pc_q + 32'd4;
        end
      end
      S_HALT: begin
        // Drain: once downstream accepts the EBREAK, feed bubbles.
        if (!STALL) begin
          instr_id_d = NOP_INSTR;
          valid_id_d = 1'b0;
        end
      end
      default: ;
    endcase
  end

  // PC and IF/ID pipeline registers.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      pc_q       <= RESET_PC;
      pc_id_q    <= 32'd0;
      instr_id_q <= NOP_INSTR;
      valid_id_q <= 1'b0;
      mis_q      <= 1'b0;
    end else begin
      pc_q       <= pc_d;
      pc_id_q    <= pc_id_d;
      instr_id_q <= instr_id_d;
      valid_id_q <= valid_id_d;
      mis_q      <= mis_d;
    end
  end

  // ROM word index; PCs past the ROM alias modulo its size.
  assign INS_ADDRESS    = pc_q[AW+1:2];
  assign PC_ID          = pc_id_q;
  assign INSTRUCTION_ID = instr_id_q;
  assign VALID_ID       = valid_id_q;
  assign MISALIGNED     = mis_q;

endmodule

`default_nettype wire

// File: tb/tb_fetch_stage.sv
//==============================================================================
// Module   : tb_fetch_stage
// Brief    : Directed self-checking bench for fetch_stage with a behavioural
//            asynchronous ROM.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_fetch_stage;

  localparam logic [31:0] NOP    = 32'h0000_0013;
  localparam logic [31:0] EBREAK = 32'h0010_0073;

  logic        CLK = 1'b0;
  logic        RESET = 1'b1;
  logic        STALL = 1'b0;
  logic        BRANCH_TAKEN = 1'b0;
  logic [31:0] BRANCH_TARGET = 32'h0;
  logic        READ_EN;
  logic [9:0]  INS_ADDRESS;
  logic [31:0] INSTRUCTION_IN;
  logic [31:0] PC_ID;
  logic [31:0] INSTRUCTION_ID;
  logic        VALID_ID;
  logic        HALTED;
  logic        MISALIGNED;

  logic [31:0] rom [0:1023];
  int          n_pass = 0;
  int          n_total = 0;

  always #5 CLK = ~CLK;

  assign INSTRUCTION_IN = rom[INS_ADDRESS];

  fetch_stage dut (
    .CLK            (CLK),
    .RESET          (RESET),
    .STALL          (STALL),
    .BRANCH_TAKEN   (BRANCH_TAKEN),
    .BRANCH_TARGET  (BRANCH_TARGET),
    .READ_EN        (READ_EN),
    .INS_ADDRESS    (INS_ADDRESS),
    .INSTRUCTION_IN (INSTRUCTION_IN),
    .PC_ID          (PC_ID),
    .INSTRUCTION_ID (INSTRUCTION_ID),
    .VALID_ID       (VALID_ID),
    .HALTED         (HALTED),
    .MISALIGNED     (MISALIGNED)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  // Advance to just after the next rising edge.
  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  initial begin
    for (int k = 0; k < 1024; k++) rom[k] = k + 1;

    // Reset state
    #12;
    chk("rst_valid",   {31'd0, VALID_ID},   32'd0);
    chk("rst_pcid",    PC_ID,               32'd0);
    chk("rst_instr",   INSTRUCTION_ID,      NOP);
    chk("rst_halted",  {31'd0, HALTED},     32'd0);
    chk("rst_mis",     {31'd0, MISALIGNED}, 32'd0);
    chk("rst_read_en", {31'd0, READ_EN},    32'd0);
    chk("rst_addr",    {22'd0, INS_ADDRESS}, 32'd0);

    // Sequential fetch
    step(); RESET = 1'b0;
    step(); // edge 1 (BOOT)
    chk("e1_valid",   {31'd0, VALID_ID}, 32'd0);
    chk("e1_read_en", {31'd0, READ_EN},  32'd1);
    chk("e1_addr",    {22'd0, INS_ADDRESS}, 32'd0);
    step(); // edge 2
    chk("e2_pcid",  PC_ID,          32'd0);
    chk("e2_instr", INSTRUCTION_ID, 32'd1);
    chk("e2_valid", {31'd0, VALID_ID}, 32'd1);
    chk("e2_addr",  {22'd0, INS_ADDRESS}, 32'd1);
    step(); // edge 3
    chk("e3_pcid",  PC_ID,          32'd4);
    chk("e3_instr", INSTRUCTION_ID, 32'd2);
    chk("e3_addr",  {22'd0, INS_ADDRESS}, 32'd2);

    // Stall for 3 edges at PC=8
    STALL = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("stall_addr",  {22'd0, INS_ADDRESS}, 32'd2);
      chk("stall_pcid",  PC_ID,          32'd4);
      chk("stall_instr", INSTRUCTION_ID, 32'd2);
    end
    STALL = 1'b0;
    step();
    chk("post_stall_pcid",  PC_ID,          32'd8);
    chk("post_stall_instr", INSTRUCTION_ID, 32'd3);

    // Branch overriding stall
    BRANCH_TAKEN = 1'b1; STALL = 1'b1; BRANCH_TARGET = 32'h40;
    step();
    BRANCH_TAKEN = 1'b0; STALL = 1'b0;
    chk("br_valid", {31'd0, VALID_ID},   32'd0);
    chk("br_instr", INSTRUCTION_ID,      NOP);
    chk("br_addr",  {22'd0, INS_ADDRESS}, 32'd16);
    chk("br_mis",   {31'd0, MISALIGNED}, 32'd0);
    chk("br_pcid",  PC_ID,               32'd8);
    step();
    chk("br2_pcid",  PC_ID,          32'h40);
    chk("br2_instr", INSTRUCTION_ID, 32'd17);
    chk("br2_valid", {31'd0, VALID_ID}, 32'd1);

    // Misaligned target
    BRANCH_TAKEN = 1'b1; BRANCH_TARGET = 32'h43;
    step();
    BRANCH_TAKEN = 1'b0;
    chk("mis_addr",  {22'd0, INS_ADDRESS}, 32'd16);
    chk("mis_pulse", {31'd0, MISALIGNED}, 32'd1);
    chk("mis_valid", {31'd0, VALID_ID},   32'd0);
    step();
    chk("mis_clear", {31'd0, MISALIGNED}, 32'd0);
    chk("mis_pcid",  PC_ID,               32'h40);

    // Wrap at the top of the ROM
    BRANCH_TAKEN = 1'b1; BRANCH_TARGET = 32'h0000_0FFC;
    step();
    BRANCH_TAKEN = 1'b0;
    chk("wrap_addr_top", {22'd0, INS_ADDRESS}, 32'd1023);
    step();
    chk("wrap_pcid",  PC_ID,          32'h0FFC);
    chk("wrap_instr", INSTRUCTION_ID, 32'd1024);
    chk("wrap_addr0", {22'd0, INS_ADDRESS}, 32'd0);
    step();
    chk("alias_pcid",  PC_ID,          32'h1000);
    chk("alias_instr", INSTRUCTION_ID, 32'd1);

    // Asynchronous reset between edges
    #2 RESET = 1'b1;
    #1;
    chk("arst_valid",   {31'd0, VALID_ID},    32'd0);
    chk("arst_pcid",    PC_ID,                32'd0);
    chk("arst_instr",   INSTRUCTION_ID,       NOP);
    chk("arst_read_en", {31'd0, READ_EN},     32'd0);
    chk("arst_addr",    {22'd0, INS_ADDRESS}, 32'd0);

    // EBREAK halt
    rom[3] = EBREAK;
    step(); RESET = 1'b0;
    step(); step(); step(); step(); // BOOT, PC_ID 0, 4, 8
    chk("pre_halt_pcid", PC_ID, 32'd8);
    step();
    chk("halt_pcid",    PC_ID,             32'd12);
    chk("halt_instr",   INSTRUCTION_ID,    EBREAK);
    chk("halt_valid",   {31'd0, VALID_ID}, 32'd1);
    chk("halt_halted",  {31'd0, HALTED},   32'd1);
    chk("halt_read_en", {31'd0, READ_EN},  32'd0);
    chk("halt_addr",    {22'd0, INS_ADDRESS}, 32'd3);
    step();
    chk("halt_drain_valid", {31'd0, VALID_ID}, 32'd0);
    chk("halt_drain_instr", INSTRUCTION_ID,    NOP);
    BRANCH_TARGET = 32'h80;
    for (int i = 0; i < 10; i++) begin
      BRANCH_TAKEN = (i % 2 == 0);
      step();
      chk("halt_pc_frozen", {22'd0, INS_ADDRESS}, 32'd3);
      chk("halt_stays",     {31'd0, HALTED},      32'd1);
    end
    BRANCH_TAKEN = 1'b0;

    // Reset while halted
    #2 RESET = 1'b1;
    #1;
    chk("halt_rst_halted", {31'd0, HALTED}, 32'd0);
    chk("halt_rst_pcid",   PC_ID,           32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

`default_nettype wire
